pmu_norm_array: RTL and testbench

- Parametrised path-metric unit for the Viterbi decoder. It stores N_STATES path metrics between ACSU iterations and normalises them with one of two selectable schemes.
- It also reports the best (minimum-metric) state to the TBU.
- It supports per-frame re-initialisation to a known start state, and keeps overflow and normalisation statistics for debug.
- It sits between the ACSU outputs and the ACSU/TBU metric inputs.

---
 rtl/pmu_pkg.sv | 22 ++
 rtl/pm_min_tree.sv | 40 ++++
 rtl/pmu_norm_array.sv | 114 +++++++++++
 tb/tb_pmu_norm_array.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// Shared constants and helpers for the Viterbi path-metric unit.
package pmu_pkg;

  localparam int NORM_SUB_MIN = 0;
  localparam int NORM_MSB_CLR = 1;
  localparam int PMU_N_STATES = 4;
  localparam int PMU_PM_WIDTH = 8;

  // Ceiling log2; returns 0 for a value of 1.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pm_min_tree.sv
// Balanced argmin tree over the flattened metric vector; lowest index wins ties.
module pm_min_tree
  import pmu_pkg::*;
#(
  parameter int N_STATES = PMU_N_STATES,
  parameter int PM_WIDTH = PMU_PM_WIDTH,
  localparam int IW = clog2(N_STATES)
) (
  input  logic [N_STATES*PM_WIDTH-1:0] pm,
  output logic [PM_WIDTH-1:0]          min_val,
  output logic [IW-1:0]                min_idx
);

  // Heap-ordered nodes: leaves at N_STATES..2*N_STATES-1, root at 1.
  logic [PM_WIDTH-1:0] node_val_s [1:2*N_STATES-1];
  logic [IW-1:0]       node_idx_s [1:2*N_STATES-1];

  // Fill the leaves, then reduce pairwise towards the root; the left child holds lower indices.
  always_comb begin
    node_val_s = '{default: {PM_WIDTH{1'b0}}};
    node_idx_s = '{default: {IW{1'b0}}};
    for (int s = 0; s < N_STATES; s++) begin
      node_val_s[N_STATES+s] = pm[s*PM_WIDTH +: PM_WIDTH];
      node_idx_s[N_STATES+s] = IW'(s);
    end
    for (int k = N_STATES - 1; k >= 1; k--) begin
      if (node_val_s[2*k+1] < node_val_s[2*k]) begin
        node_val_s[k] = node_val_s[2*k+1];
        node_idx_s[k] = node_idx_s[2*k+1];
      end else begin
        node_val_s[k] = node_val_s[2*k];
        node_idx_s[k] = node_idx_s[2*k];
      end
    end
  end

  assign min_val = node_val_s[1];
  assign min_idx = node_idx_s[1];

endmodule

// File: rtl/pmu_norm_array.sv
// Path-metric store for the Viterbi decoder: normalises ACSU results, reports the
// best state, and keeps overflow/normalisation statistics.
module pmu_norm_array
  import pmu_pkg::*;
#(
  parameter int N_STATES  = PMU_N_STATES,
  parameter int PM_WIDTH  = PMU_PM_WIDTH,
  parameter int NORM_MODE = NORM_SUB_MIN,
  parameter int INIT_BAD  = 2 ** (PM_WIDTH - 1),
  parameter int CNT_WIDTH = 16,
  localparam int IW = clog2(N_STATES),
  localparam int PW = N_STATES * PM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic                 sof_i,
  input  logic [IW-1:0]        init_state_i,
  input  logic [PW-1:0]        pm_new_i,
  output logic [PW-1:0]        pm_cur_o,
  output logic [IW-1:0]        best_state_o,
  output logic                 best_valid_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] norm_cnt_o
);

  localparam logic [PM_WIDTH-1:0] INIT_BAD_V = PM_WIDTH'(INIT_BAD);
  localparam logic [PM_WIDTH-1:0] MSB_MASK   = {1'b1, {(PM_WIDTH-1){1'b0}}};
  localparam logic [PM_WIDTH-1:0] ALL_ONES   = {PM_WIDTH{1'b1}};

  logic [PM_WIDTH-1:0]  min_val_s;
  logic [IW-1:0]        min_idx_s;
  logic [PW-1:0]        pm_nxt_s;
  logic                 norm_evt_s;
  logic                 all_ones_s;
  logic [PW-1:0]        pm_cur_r;
  logic [IW-1:0]        best_state_r;
  logic                 best_valid_r;
  logic                 overflow_r;
  logic [CNT_WIDTH-1:0] norm_cnt_r;

  // Start-of-frame metric vector: the known start state is free, all others are penalised.
  function automatic logic [PW-1:0] init_vec(input logic [IW-1:0] start);
    logic [PW-1:0] vec;
    for (int s = 0; s < N_STATES; s++) begin
      vec[s*PM_WIDTH +: PM_WIDTH] = (IW'(s) == start) ? {PM_WIDTH{1'b0}} : INIT_BAD_V;
    end
    return vec;
  endfunction

  pm_min_tree #(
    .N_STATES (N_STATES),
    .PM_WIDTH (PM_WIDTH)
  ) u_min_tree (
    .pm      (pm_new_i),
    .min_val (min_val_s),
    .min_idx (min_idx_s)
  );

  // Normalised next metrics, normalisation event and all-ones detection.
  always_comb begin
    pm_nxt_s   = {PW{1'b0}};
    all_ones_s = 1'b0;
    for (int s = 0; s < N_STATES; s++) begin
      all_ones_s = all_ones_s | (pm_new_i[s*PM_WIDTH +: PM_WIDTH] == ALL_ONES);
      if (NORM_MODE == NORM_SUB_MIN) begin
        pm_nxt_s[s*PM_WIDTH +: PM_WIDTH] = pm_new_i[s*PM_WIDTH +: PM_WIDTH] - min_val_s;
      end else if (min_val_s[PM_WIDTH-1]) begin
        pm_nxt_s[s*PM_WIDTH +: PM_WIDTH] = pm_new_i[s*PM_WIDTH +: PM_WIDTH] & ~MSB_MASK;
      end else begin
        pm_nxt_s[s*PM_WIDTH +: PM_WIDTH] = pm_new_i[s*PM_WIDTH +: PM_WIDTH];
      end
    end
    if (NORM_MODE == NORM_SUB_MIN) begin
      norm_evt_s = (min_val_s != {PM_WIDTH{1'b0}});
    end else begin
      norm_evt_s = min_val_s[PM_WIDTH-1];
    end
  end

  // Metric store and statistics; sof takes priority over a coincident valid step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_cur_r     <= init_vec({IW{1'b0}});
      best_state_r <= {IW{1'b0}};
      best_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      norm_cnt_r   <= {CNT_WIDTH{1'b0}};
    end else if (sof_i) begin
      pm_cur_r     <= init_vec(init_state_i);
      best_state_r <= init_state_i;
      best_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      norm_cnt_r   <= {CNT_WIDTH{1'b0}};
    end else if (valid_i) begin
      pm_cur_r     <= pm_nxt_s;
      best_state_r <= min_idx_s;
      best_valid_r <= 1'b1;
      overflow_r   <= overflow_r | all_ones_s;
      if (norm_evt_s && (norm_cnt_r != {CNT_WIDTH{1'b1}})) begin
        norm_cnt_r <= norm_cnt_r + CNT_WIDTH'(1);
      end
    end else begin
      best_valid_r <= 1'b0;
    end
  end

  assign pm_cur_o     = pm_cur_r;
  assign best_state_o = best_state_r;
  assign best_valid_o = best_valid_r;
  assign overflow_o   = overflow_r;
  assign norm_cnt_o   = norm_cnt_r;

endmodule

// File: tb/tb_pmu_norm_array.sv
// Self-checking bench: directed vectors on 4-state instances of both modes, then a
// scoreboarded random run on 64-state instances against a reference model.
module tb_pmu_norm_array;

  logic clk;
  logic rst_n;

  // Small instances (N=4, W=8) share stimulus; mode 0 uses a 4-bit counter.
  logic        valid_a, sof_a;
  logic [1:0]  init_a;
  logic [31:0] nw_a;
  logic [31:0] p0, p1;
  logic [1:0]  b0, b1;
  logic        v0, v1, o0, o1;
  logic [3:0]  c0;
  logic [15:0] c1;

  // Large instances (N=64, W=10) share stimulus.
  logic         valid_b, sof_b;
  logic [5:0]   init_b;
  logic [639:0] nw_b;
  logic [639:0] p2, p3;
  logic [5:0]   b2, b3;
  logic         v2, v3, o2, o3;
  logic [15:0]  c2, c3;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic valid; logic sof; logic [1:0] init; logic [31:0] nw;
    logic [31:0] ep0; logic [1:0] eb0; logic ev0; logic eo0; logic [3:0] ec0;
    logic [31:0] ep1; logic [1:0] eb1; logic ev1; logic eo1; logic [15:0] ec1;
  } rec_t;

  typedef struct packed {
    logic [639:0] pm; logic [5:0] best; logic bv; logic ovf; logic [15:0] cnt;
  } big_t;

  typedef struct packed { big_t m0; big_t m1; } pair_t;

  rec_t  vecs [13];
  pair_t sbq [$];

  pmu_norm_array #(.N_STATES(4), .PM_WIDTH(8), .NORM_MODE(0), .CNT_WIDTH(4)) u_s0 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_a), .sof_i(sof_a), .init_state_i(init_a),
    .pm_new_i(nw_a), .pm_cur_o(p0), .best_state_o(b0), .best_valid_o(v0),
    .overflow_o(o0), .norm_cnt_o(c0));

  pmu_norm_array #(.N_STATES(4), .PM_WIDTH(8), .NORM_MODE(1), .CNT_WIDTH(16)) u_s1 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_a), .sof_i(sof_a), .init_state_i(init_a),
    .pm_new_i(nw_a), .pm_cur_o(p1), .best_state_o(b1), .best_valid_o(v1),
    .overflow_o(o1), .norm_cnt_o(c1));

  pmu_norm_array #(.N_STATES(64), .PM_WIDTH(10), .NORM_MODE(0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_b), .sof_i(sof_b), .init_state_i(init_b),
    .pm_new_i(nw_b), .pm_cur_o(p2), .best_state_o(b2), .best_valid_o(v2),
    .overflow_o(o2), .norm_cnt_o(c2));

  pmu_norm_array #(.N_STATES(64), .PM_WIDTH(10), .NORM_MODE(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_b), .sof_i(sof_b), .init_state_i(init_b),
    .pm_new_i(nw_b), .pm_cur_o(p3), .best_state_o(b3), .best_valid_o(v3),
    .overflow_o(o3), .norm_cnt_o(c3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [671:0] act, input logic [671:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic rec_t mk(input logic va, input logic so, input int in, input logic [31:0] nw,
                              input logic [31:0] ep0, input int eb0, input logic ev0, input logic eo0, input int ec0,
                              input logic [31:0] ep1, input int eb1, input logic ev1, input logic eo1, input int ec1);
    rec_t r;
    r.valid = va; r.sof = so; r.init = in[1:0]; r.nw = nw;
    r.ep0 = ep0; r.eb0 = eb0[1:0]; r.ev0 = ev0; r.eo0 = eo0; r.ec0 = ec0[3:0];
    r.ep1 = ep1; r.eb1 = eb1[1:0]; r.ev1 = ev1; r.eo1 = eo1; r.ec1 = ec1[15:0];
    return r;
  endfunction

  // Reference: linear scan for the first minimum, then the chosen normalisation.
  function automatic big_t model(input big_t st, input int mode, input logic va, input logic so,
                                 input logic [5:0] in, input logic [639:0] nw);
    big_t r;
    int mi;
    logic [9:0] mv, v;
    logic evt;
    r = st;
    if (so) begin
      for (int s = 0; s < 64; s++) r.pm[s*10 +: 10] = (s == int'(in)) ? 10'd0 : 10'd512;
      r.best = in; r.bv = 1'b0; r.ovf = 1'b0; r.cnt = 16'd0;
    end else if (va) begin
      mi = 0;
      mv = nw[9:0];
      for (int s = 1; s < 64; s++) begin
        if (nw[s*10 +: 10] < mv) begin
          mv = nw[s*10 +: 10];
          mi = s;
        end
      end
      for (int s = 0; s < 64; s++) begin
        v = nw[s*10 +: 10];
        if (v == 10'h3ff) r.ovf = 1'b1;
        if (mode == 0) r.pm[s*10 +: 10] = v - mv;
        else r.pm[s*10 +: 10] = mv[9] ? {1'b0, v[8:0]} : v;
      end
      evt = (mode == 0) ? (mv != 10'd0) : mv[9];
      if (evt && r.cnt != 16'hffff) r.cnt = r.cnt + 16'd1;
      r.best = mi[5:0];
      r.bv = 1'b1;
    end else begin
      r.bv = 1'b0;
    end
    return r;
  endfunction

  task automatic check_small(input string tag, input rec_t e);
    check({tag, "_pm0"}, 672'(p0), 672'(e.ep0));
    check({tag, "_best0"}, 672'(b0), 672'(e.eb0));
    check({tag, "_bv0"}, 672'(v0), 672'(e.ev0));
    check({tag, "_ovf0"}, 672'(o0), 672'(e.eo0));
    check({tag, "_cnt0"}, 672'(c0), 672'(e.ec0));
    check({tag, "_pm1"}, 672'(p1), 672'(e.ep1));
    check({tag, "_best1"}, 672'(b1), 672'(e.eb1));
    check({tag, "_bv1"}, 672'(v1), 672'(e.ev1));
    check({tag, "_ovf1"}, 672'(o1), 672'(e.eo1));
    check({tag, "_cnt1"}, 672'(c1), 672'(e.ec1));
  endtask

  initial begin
    rec_t rst_exp;
    big_t m0, m1;
    pair_t ex;
    logic [639:0] nw;
    int prof, cexp;

    rst_n = 1'b0;
    valid_a = 1'b0; sof_a = 1'b0; init_a = 2'd0; nw_a = 32'd0;
    valid_b = 1'b0; sof_b = 1'b0; init_b = 6'd0; nw_b = 640'd0;

    vecs[0]  = mk(1, 0, 0, pk(10, 7, 7, 20),    pk(3, 0, 0, 13),    1, 1, 0, 1, pk(10, 7, 7, 20),    1, 1, 0, 0);
    vecs[1]  = mk(1, 0, 0, pk(0, 5, 9, 9),      pk(0, 5, 9, 9),     0, 1, 0, 1, pk(0, 5, 9, 9),      0, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0, pk(200, 130, 129, 255), pk(71, 1, 0, 126), 2, 1, 1, 2, pk(72, 2, 1, 127),  2, 1, 1, 1);
    vecs[3]  = mk(1, 0, 0, pk(200, 100, 150, 180), pk(100, 0, 50, 80), 1, 1, 1, 3, pk(200, 100, 150, 180), 1, 1, 1, 1);
    for (int i = 4; i < 9; i++)
      vecs[i] = mk(0, 0, 0, pk(1, 2, 3, 4),     pk(100, 0, 50, 80), 1, 0, 1, 3, pk(200, 100, 150, 180), 1, 0, 1, 1);
    vecs[9]  = mk(1, 1, 2, pk(1, 1, 1, 1),      pk(128, 128, 0, 128), 2, 0, 0, 0, pk(128, 128, 0, 128), 2, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, pk(128, 255, 200, 130), pk(0, 127, 72, 2), 0, 1, 1, 1, pk(0, 127, 72, 2),  0, 1, 1, 1);
    vecs[11] = mk(0, 1, 3, pk(0, 0, 0, 0),      pk(128, 128, 128, 0), 3, 0, 0, 0, pk(128, 128, 128, 0), 3, 0, 0, 0);
    vecs[12] = mk(1, 0, 0, pk(3, 3, 3, 3),      pk(0, 0, 0, 0),     0, 1, 0, 1, pk(3, 3, 3, 3),      0, 1, 0, 0);
    rst_exp  = mk(0, 0, 0, 32'd0,               pk(0, 128, 128, 128), 0, 0, 0, 0, pk(0, 128, 128, 128), 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_small("reset", rst_exp);

    for (int i = 0; i < 13; i++) begin
      valid_a = vecs[i].valid; sof_a = vecs[i].sof; init_a = vecs[i].init; nw_a = vecs[i].nw;
      @(negedge clk);
      check_small($sformatf("vec%0d", i), vecs[i]);
    end

    // Mode-0 counter (4 bits) saturates at 15 under continuous normalisation.
    valid_a = 1'b1; sof_a = 1'b0; nw_a = pk(5, 6, 7, 8);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cexp = (1 + k > 15) ? 15 : 1 + k;
      check($sformatf("sat%0d_cnt0", k), 672'(c0), 672'(cexp));
      check($sformatf("sat%0d_pm0", k), 672'(p0), 672'(pk(0, 1, 2, 3)));
      check($sformatf("sat%0d_cnt1", k), 672'(c1), 672'(0));
    end

    // Asynchronous reset between clock edges restores the reset state immediately.
    nw_a = pk(9, 9, 9, 1);
    @(negedge clk);
    check("prerst_best0", 672'(b0), 672'(3));
    check("prerst_pm0", 672'(p0), 672'(pk(8, 8, 8, 0)));
    valid_a = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_small("async_rst", rst_exp);
    @(negedge clk);
    rst_n = 1'b1;

    // Random back-to-back steps on the 64-state instances, scoreboarded one cycle behind.
    m0 = model(m0, 0, 1'b0, 1'b1, 6'd0, 640'd0);
    m1 = model(m1, 1, 1'b0, 1'b1, 6'd0, 640'd0);
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        ex = sbq.pop_front();
        check($sformatf("rnd%0d_m0", c), 672'({p2, b2, v2, o2, c2}), 672'(ex.m0));
        check($sformatf("rnd%0d_m1", c), 672'({p3, b3, v3, o3, c3}), 672'(ex.m1));
      end
      prof = $urandom_range(0, 3);
      for (int s = 0; s < 64; s++) begin
        case (prof)
          0: nw[s*10 +: 10] = 10'($urandom_range(0, 1023));
          1: nw[s*10 +: 10] = 10'($urandom_range(512, 1023));
          2: nw[s*10 +: 10] = 10'($urandom_range(5, 8));
          default: nw[s*10 +: 10] = ($urandom_range(0, 15) == 0) ? 10'h3ff : 10'($urandom_range(0, 1023));
        endcase
      end
      valid_b = ($urandom_range(0, 7) != 0);
      sof_b   = ($urandom_range(0, 63) == 0);
      init_b  = 6'($urandom_range(0, 63));
      nw_b    = nw;
      m0 = model(m0, 0, valid_b, sof_b, init_b, nw_b);
      m1 = model(m1, 1, valid_b, sof_b, init_b, nw_b);
      sbq.push_back({m0, m1});
    end
    @(negedge clk);
    valid_b = 1'b0; sof_b = 1'b0;
    ex = sbq.pop_front();
    check("rnd_last_m0", 672'({p2, b2, v2, o2, c2}), 672'(ex.m0));
    check("rnd_last_m1", 672'({p3, b3, v3, o3, c3}), 672'(ex.m1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
